// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, its two requesters and the main memory.
// slave modport: the arbiter's view. master modport: the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // IF stage (read-only)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // MEM stage (load/store)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // Main memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D).
// Each access holds the port MEM_LAT cycles, then pulses the owner's ack for one cycle.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise D has priority, with a STARVE_MAX guard that forces an I grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  arb_io
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant;  // an access is accepted this cycle
  logic win_d;  // D wins the current arbitration

  assign grant = (state_q == StIdle) && (arb_io.i_req || arb_io.d_req);

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  // Round-robin: on a tie grant whoever was not granted last
  always_comb begin
    win_d  = arb_io.d_req;
    last_d = last_q;
    if (arb_io.d_req && arb_io.i_req) begin
      win_d = (last_q == OwnI);
    end
    if (grant) begin
      last_d = win_d ? OwnD : OwnI;
    end
  end

  // Last-grant flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OwnI;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

  logic [StarveW-1:0] starve_q, starve_d;

  // D priority; once STARVE_MAX D grants were made over a waiting I, I wins the next tie
  always_comb begin
    win_d    = arb_io.d_req && (!arb_io.i_req || (starve_q != StarveLim));
    starve_d = starve_q;
    if (grant) begin
      if (win_d && arb_io.i_req) begin
        starve_d = starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Access sequencer: latch on grant, count down the port hold, capture read data
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = win_d ? OwnD : OwnI;
          addr_d  = win_d ? arb_io.d_addr : arb_io.i_addr;
          we_d    = win_d && arb_io.d_we;
          if (win_d) begin
            wdata_d = arb_io.d_wdata;
          end
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OwnD) begin
              d_rdata_d = arb_io.mem_rdata;
            end else begin
              i_rdata_d = arb_io.mem_rdata;
            end
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        // One cycle for the requester to drop or change req before re-arbitration
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      owner_q   <= OwnI;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode from registered state only, so async reset clears them at once
  always_comb begin
    arb_io.busy      = (state_q != StIdle);
    arb_io.mem_read  = (state_q == StBusy) && !we_q;
    // Single write strobe in the final hold cycle; memory commits on the falling edge
    arb_io.mem_write = (state_q == StBusy) && we_q && (cnt_q == '0);
    arb_io.i_ack     = (state_q == StDone) && (owner_q == OwnI);
    arb_io.d_ack     = (state_q == StDone) && (owner_q == OwnD);
    arb_io.mem_addr  = addr_q;
    arb_io.mem_wdata = wdata_q;
    arb_io.i_rdata   = i_rdata_q;
    arb_io.d_rdata   = d_rdata_q;
  end

endmodule
